// File: rtl/debug_mem_dump.sv
// ---------------------------------------------------------------------------
// debug_mem_dump
//
// Purpose:
//   Debug-unit reader for the data memory's debug port. When a dump is
//   requested while the pipeline is halted, it walks every word-aligned
//   data-memory address, latches the word the MEM stage returns
//   combinationally, and sends the word to the UART transmitter as four
//   bytes, most significant byte first, using a start/done handshake.
//
// Ports:
//   i_clk              clock
//   i_reset            synchronous, active-high reset
//   i_start            single-cycle request to dump all of data memory
//   i_halted           pipeline halted; the debug port is valid only while high
//   o_address_to_read  byte address to the MEM stage debug port (low 2 bits 00)
//   i_mem_content      word at o_address_to_read, combinational from memory
//   o_tx_data          byte to the UART transmitter
//   o_tx_start         one-cycle pulse, o_tx_data valid in the same cycle
//   i_tx_done          UART transmitter finished the current byte (pulse)
//   o_busy             high in every state except IDLE
//   o_done             one-cycle pulse after the last byte of the last word
// ---------------------------------------------------------------------------
module debug_mem_dump #(
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic                      i_halted,
    output logic [MEM_ADDR_WIDTH-1:0] o_address_to_read,
    input  logic [DATA_WIDTH*4-1:0]   i_mem_content,
    output logic [7:0]                o_tx_data,
    output logic                      o_tx_start,
    input  logic                      i_tx_done,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int WORD_WIDTH = DATA_WIDTH * 4;

    // Address of the last word; the sweep ends when this word has been sent,
    // so the terminal test never relies on the address wrapping to zero.
    localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR = {{(MEM_ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_STEP = MEM_ADDR_WIDTH'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET_ADDR,
        S_LATCH,
        S_SEND,
        S_WAIT_TX,
        S_DONE
    } state_t;

    state_t                state;
    logic [WORD_WIDTH-1:0] word_latch;
    logic [1:0]            byte_idx;

    // Selects byte idx of a word; idx 3 is the most significant byte.
    function automatic logic [7:0] pick_byte(input logic [WORD_WIDTH-1:0] word,
                                             input logic [1:0]            idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

    // Whole controller in one registered process. All outputs are registers,
    // so each output is loaded on the transition into the state that owns it:
    // o_tx_start/o_tx_data when entering SEND, o_done when entering DONE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state             <= S_IDLE;
            o_address_to_read <= '0;
            o_tx_data         <= 8'h00;
            o_tx_start        <= 1'b0;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
            word_latch        <= '0;
            byte_idx          <= 2'd0;
        end else begin
            o_tx_start <= 1'b0;
            o_done     <= 1'b0;

            // Losing the halt invalidates the debug port, so any dump in
            // progress is abandoned. A byte already handed to the UART is
            // left to finish on its own; o_tx_data keeps its last value.
            if (state != S_IDLE && !i_halted) begin
                state             <= S_IDLE;
                o_busy            <= 1'b0;
                o_address_to_read <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_start && i_halted) begin
                            state             <= S_SET_ADDR;
                            o_busy            <= 1'b1;
                            o_address_to_read <= '0;
                        end
                    end

                    // One full cycle for the memory read path to settle on
                    // the newly presented address.
                    S_SET_ADDR: begin
                        state <= S_LATCH;
                    end

                    // The first byte is taken straight from the memory word
                    // on the same edge that fills the latch, so it is ready
                    // together with the start pulse in SEND.
                    S_LATCH: begin
                        word_latch <= i_mem_content;
                        byte_idx   <= 2'd3;
                        o_tx_data  <= pick_byte(i_mem_content, 2'd3);
                        o_tx_start <= 1'b1;
                        state      <= S_SEND;
                    end

                    S_SEND: begin
                        state <= S_WAIT_TX;
                    end

                    // A finished byte either releases the next byte of the
                    // same word, moves to the next word, or ends the sweep.
                    S_WAIT_TX: begin
                        if (i_tx_done) begin
                            if (byte_idx != 2'd0) begin
                                byte_idx   <= byte_idx - 2'd1;
                                o_tx_data  <= pick_byte(word_latch, byte_idx - 2'd1);
                                o_tx_start <= 1'b1;
                                state      <= S_SEND;
                            end else if (o_address_to_read == LAST_ADDR) begin
                                o_done <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                o_address_to_read <= o_address_to_read + ADDR_STEP;
                                state             <= S_SET_ADDR;
                            end
                        end
                    end

                    S_DONE: begin
                        o_busy            <= 1'b0;
                        o_address_to_read <= '0;
                        state             <= S_IDLE;
                    end

                    default: begin
                        o_busy            <= 1'b0;
                        o_address_to_read <= '0;
                        state             <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_debug_mem_dump.sv
// ---------------------------------------------------------------------------
// tb_debug_mem_dump
//
// Purpose:
//   Self-checking bench for debug_mem_dump at the default 8-bit address
//   width (64 words, 256 bytes). A cycle-by-cycle vector table covers reset,
//   the not-halted case, one hand-timed word with spurious handshakes and an
//   abort. Full sweeps then run against a random-latency UART model and a
//   reference byte stream computed from the memory contents.
// ---------------------------------------------------------------------------
module tb_debug_mem_dump;

    localparam int AW    = 8;
    localparam int WORDS = 1 << (AW - 2);
    localparam int BYTES = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          halted;
    logic          tx_done;
    logic [AW-1:0] address;
    logic [31:0]   mem_content;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          busy;
    logic          done;

    logic [31:0]   mem [0:WORDS-1];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory debug port: combinational read of the addressed word.
    assign mem_content = mem[address[AW-1:2]];

    debug_mem_dump #(
        .MEM_ADDR_WIDTH(AW),
        .DATA_WIDTH    (8)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_start          (start),
        .i_halted         (halted),
        .o_address_to_read(address),
        .i_mem_content    (mem_content),
        .o_tx_data        (tx_data),
        .o_tx_start       (tx_start),
        .i_tx_done        (tx_done),
        .o_busy           (busy),
        .o_done           (done)
    );

    typedef struct {
        logic       rst;
        logic       st;
        logic       hl;
        logic       td;
        logic [7:0] addr;
        logic [7:0] data;
        logic       tx_st;
        logic       bsy;
        logic       dn;
    } vec_t;

    vec_t vecs [17];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drives one row's inputs at a falling edge and waits for the next
    // falling edge, so the row's expectations see the result of one rising edge.
    task automatic apply_stimulus(input vec_t v);
        reset   = v.rst;
        start   = v.st;
        halted  = v.hl;
        tx_done = v.td;
        if (v.rst) begin
            start   = 1'($urandom_range(0, 1));
            halted  = 1'($urandom_range(0, 1));
            tx_done = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
    endtask

    // Byte i of a full sweep: word i/4, most significant byte first.
    function automatic logic [7:0] ref_byte(input int i);
        logic [31:0] w;
        w = mem[i / 4];
        return 8'((w >> (8 * (3 - (i % 4)))) & 32'hFF);
    endfunction

    function automatic logic [AW-1:0] ref_addr(input int i);
        return AW'(4 * (i / 4));
    endfunction

    // Runs a dump against a UART model with random per-byte latency, random
    // i_start pulses and occasional spurious i_tx_done right after a real one.
    // With abort_at > 0 the halt is dropped while waiting for that byte.
    task automatic run_dump(input int abort_at);
        logic [7:0]    got_bytes [$];
        logic [AW-1:0] got_addr  [$];
        int  countdown   = 0;
        int  acked       = 0;
        int  exp_start_at;
        int  exp_done_at = -1;
        int  n_expected;
        bit  finished    = 1'b0;
        bit  aborted     = 1'b0;
        bit  prev_real   = 1'b0;
        bit  real_done;

        n_expected   = (abort_at > 0) ? abort_at : BYTES;
        halted       = 1'b1;
        start        = 1'b1;
        tx_done      = 1'b0;
        exp_start_at = cyc + 3;
        @(negedge clk);
        start = 1'b0;

        for (int k = 0; k < 6000; k++) begin
            if (tx_start) begin
                check_output("start latency", cyc, exp_start_at);
                got_bytes.push_back(tx_data);
                got_addr.push_back(address);
                countdown = $urandom_range(2, 5);
            end
            if (done) begin
                check_output("done latency", cyc, exp_done_at);
                finished = 1'b1;
                break;
            end
            if (abort_at > 0 && got_bytes.size() == abort_at) begin
                aborted = 1'b1;
                break;
            end
            real_done = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) real_done = 1'b1;
            end
            tx_done   = real_done || (prev_real && ($urandom_range(0, 1) == 1));
            prev_real = real_done;
            if (real_done) begin
                acked++;
                if (acked == BYTES)    exp_done_at  = cyc + 1;
                else if (acked % 4 != 0) exp_start_at = cyc + 1;
                else                   exp_start_at = cyc + 3;
            end
            start = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end

        start   = 1'b0;
        tx_done = 1'b0;
        if (aborted) begin
            @(negedge clk);
            check_output("busy while waiting", 32'(busy), 32'd1);
            halted = 1'b0;
            @(negedge clk);
            check_output("abort busy", 32'(busy), 32'd0);
            check_output("abort tx_start", 32'(tx_start), 32'd0);
            check_output("abort done", 32'(done), 32'd0);
            check_output("abort address", 32'(address), 32'd0);
            halted = 1'b1;
            repeat (4) begin
                @(negedge clk);
                check_output("no done after abort", 32'(done), 32'd0);
                check_output("idle after abort", 32'(busy), 32'd0);
            end
        end else begin
            check_output("dump finished", 32'(finished), 32'd1);
            @(negedge clk);
            check_output("end busy", 32'(busy), 32'd0);
            check_output("end address", 32'(address), 32'd0);
            check_output("end done", 32'(done), 32'd0);
        end

        check_output("byte count", got_bytes.size(), n_expected);
        for (int i = 0; i < got_bytes.size() && i < n_expected; i++) begin
            check_output($sformatf("byte %0d", i), 32'(got_bytes[i]), 32'(ref_byte(i)));
            check_output($sformatf("addr of byte %0d", i), 32'(got_addr[i]), 32'(ref_addr(i)));
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        halted  = 1'b0;
        tx_done = 1'b0;
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'hDEADBEEF;

        //           rst   st    hl    td    addr   data   txst  busy  done
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hDE, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hDE, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hDE, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hAD, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hAD, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hBE, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hBE, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hEF, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hEF, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h04, 8'hEF, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hEF, 1'b0, 1'b0, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("row %0d address", i), 32'(address), 32'(vecs[i].addr));
            check_output($sformatf("row %0d tx_data", i), 32'(tx_data), 32'(vecs[i].data));
            check_output($sformatf("row %0d tx_start", i), 32'(tx_start), 32'(vecs[i].tx_st));
            check_output($sformatf("row %0d busy", i), 32'(busy), 32'(vecs[i].bsy));
            check_output($sformatf("row %0d done", i), 32'(done), 32'(vecs[i].dn));
        end

        // Full sweep with a recognisable pattern: bytes 0x00..0xFF in order.
        for (int w = 0; w < WORDS; w++)
            mem[w] = {8'(4 * w), 8'(4 * w + 1), 8'(4 * w + 2), 8'(4 * w + 3)};
        $display("[TB] full sweep, counting pattern");
        run_dump(0);

        // Random contents: abort during byte 2 of word 5, then a fresh dump
        // must restart from address 0.
        for (int w = 0; w < WORDS; w++) mem[w] = $urandom;
        $display("[TB] abort then restart");
        run_dump(5 * 4 + 3);
        run_dump(0);

        // Reset in the middle of a dump overrides everything.
        $display("[TB] reset mid-dump");
        halted = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_output("busy before reset", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset tx_start", 32'(tx_start), 32'd0);
        check_output("reset tx_data", 32'(tx_data), 32'd0);
        check_output("reset address", 32'(address), 32'd0);
        check_output("reset done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_output("idle after reset", 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
